// File: rtl/dm_pkg.sv
// Shared constants and helpers for the data-memory responder.
// Holds the word-address width, MMIO register offsets within the 16-word
// window, the console status field positions, and the address region enum.
package dm_pkg;

  localparam int ADDR_W = 14;

  // Word offsets inside the MMIO window
  localparam logic [3:0] OFF_CYCLE_LO = 4'd0;
  localparam logic [3:0] OFF_CYCLE_HI = 4'd1;
  localparam logic [3:0] OFF_CONSOLE  = 4'd2;
  localparam logic [3:0] OFF_TOHOST   = 4'd3;

  // CONSOLE read layout: {16'b0, drop_cnt, 4'b0, count[3:0]}
  localparam int CON_COUNT_LSB = 0;
  localparam int CON_COUNT_W   = 4;
  localparam int CON_DROP_LSB  = 8;
  localparam int CON_DROP_W    = 8;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CYCLE_LO,
    REG_CYCLE_HI,
    REG_CONSOLE,
    REG_TOHOST,
    REG_NONE
  } region_e;

  function automatic logic [31:0] console_status(input logic [CON_DROP_W-1:0]  drop,
                                                 input logic [CON_COUNT_W-1:0] count);
    logic [31:0] s;
    s = '0;
    s[CON_DROP_LSB +: CON_DROP_W]   = drop;
    s[CON_COUNT_LSB +: CON_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// SRAM-style CPU data-memory port.
//   DM_WEB   write enable, active-low
//   DM_BWEB  per-bit write enable, active-low
//   DM_A     word address
//   DM_IN    write data
//   DM_OUT   registered read data (one-cycle latency)
// master = CPU side, slave = memory responder side.
interface dm_responder_if
  import dm_pkg::*;
#(
  parameter int AW = ADDR_W
) ();

  logic          DM_WEB;
  logic [31:0]   DM_BWEB;
  logic [AW-1:0] DM_A;
  logic [31:0]   DM_IN;
  logic [31:0]   DM_OUT;

  modport master (
    output DM_WEB, DM_BWEB, DM_A, DM_IN,
    input  DM_OUT
  );

  modport slave (
    input  DM_WEB, DM_BWEB, DM_A, DM_IN,
    output DM_OUT
  );

endinterface

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console valid/ready port.
//   push/data_in  enqueue request; accepted when not full, or when full with a
//                 pop in the same cycle
//   pop           dequeue request; ignored when empty
//   head          oldest entry, forced to zero while empty
//   count         number of stored entries (0..DEPTH)
//   full/empty    status flags
// Pointers carry one extra MSB so full and empty are distinguishable.
module console_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= data_in;
  end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the CPU data-memory port.
// Word RAM below MMIO_BASE, 16-word MMIO window at MMIO_BASE:
//   +0 CYCLE_LO, +1 CYCLE_HI (64-bit free-running cycle counter, read-only)
//   +2 CONSOLE  (write pushes a byte, read returns drop/count status)
//   +3 TOHOST   (first write latches exit_code and raises halt)
// Ports:
//   clk, rst         clock and asynchronous active-low reset
//   dm               CPU data-memory port (slave side)
//   con_valid/data/ready   console byte stream out of the FIFO
//   halt, exit_code  sticky end-of-test indication
module dm_responder
  import dm_pkg::*;
#(
  parameter int                ADDR_W     = dm_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 14'h3FF0,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  dm_responder_if.slave     dm,
  output logic              con_valid,
  output logic [7:0]        con_data,
  input  logic              con_ready,
  output logic              halt,
  output logic [31:0]       exit_code
);

  localparam int RAM_WORDS = int'(MMIO_BASE);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       mem [RAM_WORDS];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] mmio_off_full;
  region_e           region;
  logic [31:0]       rd_data;
  logic [31:0]       ram_wdata;
  logic              ram_wr;
  logic              mmio_wr_ok;
  logic              con_push;
  logic              con_pop;
  logic              tohost_wr;
  logic [63:0]       cycle_cnt;
  logic [7:0]        drop_cnt;
  logic [7:0]        fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign addr          = dm.DM_A;
  assign mmio_off_full = addr - MMIO_BASE;

  always_comb begin
    region = REG_NONE;
    if (addr < MMIO_BASE) begin
      region = REG_RAM;
    end else if (mmio_off_full < ADDR_W'(16)) begin
      case (mmio_off_full[3:0])
        OFF_CYCLE_LO: region = REG_CYCLE_LO;
        OFF_CYCLE_HI: region = REG_CYCLE_HI;
        OFF_CONSOLE:  region = REG_CONSOLE;
        OFF_TOHOST:   region = REG_TOHOST;
        default:      region = REG_NONE;
      endcase
    end
  end

  // MMIO stores need the low byte lanes fully enabled.
  assign mmio_wr_ok = !dm.DM_WEB && (dm.DM_BWEB[7:0] == 8'h00);
  assign ram_wr     = !dm.DM_WEB && (region == REG_RAM);
  assign con_push   = mmio_wr_ok && (region == REG_CONSOLE);
  assign tohost_wr  = mmio_wr_ok && (region == REG_TOHOST);
  assign con_pop    = con_valid && con_ready;

  assign ram_wdata = (mem[addr] & dm.DM_BWEB) | (dm.DM_IN & ~dm.DM_BWEB);

  // RAM contents survive reset; a write sampled while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst && ram_wr) mem[addr] <= ram_wdata;
  end

  always_comb begin
    rd_data = '0;
    case (region)
      REG_RAM:      rd_data = mem[addr];
      REG_CYCLE_LO: rd_data = cycle_cnt[31:0];
      REG_CYCLE_HI: rd_data = cycle_cnt[63:32];
      REG_CONSOLE:  rd_data = console_status(drop_cnt, 4'(fifo_count));
      REG_TOHOST:   rd_data = exit_code;
      default:      rd_data = '0;
    endcase
  end

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_console_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (con_push),
    .data_in (dm.DM_IN[7:0]),
    .pop     (con_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm.DM_OUT <= '0;
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      // Read-first: the old word is captured even when this edge writes it.
      dm.DM_OUT <= rd_data;
      // halt is the pre-edge value, so the writing edge still counts.
      if (!halt) cycle_cnt <= cycle_cnt + 64'd1;
      if (con_push && fifo_full && !con_pop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      if (tohost_wr && !halt) begin
        halt      <= 1'b1;
        exit_code <= dm.DM_IN;
      end
    end
  end

endmodule
